vlc_bit_slicer: RTL
===================

// Module: vlc_bit_slicer
// PURPOSE
//  Downstream of the VLC receive ones-count accumulator. Slices each per-window
//  count into one bit by comparing it against a threshold.
//  Hunts for a sync word, reads a length byte, then assembles that many payload
//  bytes. Delivers the bytes to the link layer over a valid/ready interface.
// PARAMETERS
//  CNT_W      10       width of the incoming window count
//  SYNC_WORD  8'hA5    frame sync pattern; bit stream is MSB-first
//  TIMEOUT    4096     clk cycles with no cnt_valid before a locked frame aborts
//  TO_W       13       timeout counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk         in   1      clock
//  rst         in   1      asynchronous, active-low reset
//  cnt_in      in   CNT_W  ones count for the completed window
//  cnt_valid   in   1      1-cycle strobe: cnt_in/cnt_ovf valid this cycle
//  cnt_ovf     in   1      accumulator overflow for this window
//  thr         in   CNT_W  slicing threshold; quasi-static
//  byte_data   out  8      payload byte
//  byte_last   out  1      qualifies byte_data as the final byte of the frame
//  byte_valid  out  1      byte_data/byte_last valid
//  byte_ready  in   1      consumer accepts on (byte_valid & byte_ready)
//  sync_lock   out  1      high while in LEN or PAYLOAD
//  err_drop    out  1      1-cycle pulse on overrun drop or timeout abort
// BEHAVIOUR
//  Reset (rst=0, async)
//   - all outputs 0; FSM=HUNT; shift reg, bit/byte/timeout counters = 0.
//  Slicing (only on cycles with cnt_valid=1)
//   - bit = cnt_ovf | (cnt_in >= thr).
//   - sr <= {sr[6:0], bit}; cycles without cnt_valid do not shift.
//  FSM
//   - HUNT: after each shift, the new sr equals SYNC_WORD -> LEN, bitcnt=0.
//   - LEN: 8 bits -> L. L==0 -> HUNT, no output. Else -> PAYLOAD, bytecnt=0.
//   - PAYLOAD: every 8 bits completes a byte. bytecnt==L-1 -> byte_last=1,
//     then -> HUNT.
//   - A sync match inside LEN/PAYLOAD is ignored; data is never re-synced
//     mid-frame.
//  Timeout (LEN/PAYLOAD only)
//   - counter clears on every cnt_valid and increments otherwise.
//   - reaching TIMEOUT -> HUNT, err_drop pulse, partial byte discarded.
//   - counter is held at 0 in HUNT.
//  Output register (1 entry)
//   - Byte completes on the edge that samples cnt_valid in cycle N ->
//     byte_valid=1 from cycle N+1.
//   - byte_data/byte_last are stable while byte_valid & !byte_ready.
//   - byte_valid drops the cycle after acceptance unless a new byte loads.
//   - Completion in the same cycle as acceptance: new byte loads,
//     byte_valid stays 1, no drop.
//   - Completion while holding and byte_ready=0: new byte discarded, held
//     byte kept, err_drop pulse, FSM -> HUNT (frame aborted).
//   - Held byte remains deliverable after an abort; the output register is
//     cleared only by reset.
//  Widths and arithmetic
//   - L is 8-bit unsigned, giving 1..255 payload bytes.
//   - bitcnt is 3 bits and wraps 7->0 on byte completion.
//   - Compare is unsigned, CNT_W wide.
//  sync_lock is registered: it follows the FSM state with no extra cycle.
// STRUCTURE
//  Package vlc_pkg:
//   - state enum {HUNT, LEN, PAYLOAD}
//   - CNT_W, SYNC_WORD defaults
//   - BYTE_W=8
//  Sub-module vlc_out_reg: 1-entry valid/ready holding register with
//   overrun-drop flag.
//  FSM, slicer, counters and timeout stay in the top level.
// TESTING
//  1. thr=500; counts 600=1/300=0 encoding A5,03,11,22,33 -> bytes 11,22,33;
//     byte_last only with 33; sync_lock falls after the last byte.
//  2. Same frame, byte_ready=0 throughout -> 11 held; on 22 completion,
//     err_drop pulses, FSM=HUNT, byte_data stays 11.
//  3. A5,00 -> no byte_valid; sync_lock high for exactly the LEN phase,
//     then back in HUNT.
//  4. A5,02,7E then stop cnt_valid -> after TIMEOUT cycles err_drop pulses,
//     sync_lock=0, only 7E delivered, byte_last=0.
//  5. rst asserted mid-PAYLOAD -> all outputs 0 immediately; after release,
//     no bytes until a full A5 is received.
//  6. Boundaries: cnt_in=thr -> bit 1; thr-1 -> bit 0; cnt_ovf=1 with
//     cnt_in=0 -> bit 1; acceptance and completion in the same cycle ->
//     no drop.

Source files
------------

// File: rtl/vlc_pkg.sv
// Shared types and defaults for the VLC receive bit slicer.
package vlc_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned CNT_W_DEFAULT     = 10;
  localparam logic [7:0]  SYNC_WORD_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // One delivered payload byte with its end-of-frame marker.
  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } byte_beat_t;

endpackage

// File: rtl/vlc_out_reg.sv
// One-entry valid/ready holding register; flags a byte that arrives while full.
module vlc_out_reg
  import vlc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  byte_beat_t load_beat,
  input  logic       ready,
  output logic       valid,
  output byte_beat_t beat,
  output logic       drop_c
);

  // A new byte is lost only when the held one is not leaving this cycle.
  assign drop_c = load & valid & ~ready;

  // Load when empty or draining; otherwise clear valid on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (load && (!valid || ready)) begin
      valid <= 1'b1;
      beat  <= load_beat;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vlc_bit_slicer.sv
// Slices window counts into bits, frames them on a sync word and delivers bytes.
module vlc_bit_slicer
  import vlc_pkg::*;
#(
  parameter int unsigned       CNT_W     = CNT_W_DEFAULT,
  parameter logic [BYTE_W-1:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int unsigned       TIMEOUT   = 4096,
  parameter int unsigned       TO_W      = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_valid,
  input  logic              cnt_ovf,
  input  logic [CNT_W-1:0]  thr,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              sync_lock,
  output logic              err_drop
);

  state_t            state;
  // Only the seven previous bits are kept; the eighth is the one arriving.
  logic [BYTE_W-2:0] sr;
  logic [2:0]        bitcnt;
  logic [BYTE_W-1:0] len;
  logic [BYTE_W-1:0] bytecnt;
  logic [TO_W-1:0]   to_cnt;

  logic              bit_c;
  logic [BYTE_W-1:0] sr_next_c;
  logic              byte_done_c;
  logic              last_c;
  logic              to_hit_c;
  logic              drop_c;
  logic              out_valid;
  byte_beat_t        out_beat;
  byte_beat_t        load_beat_c;

  // Slice decision and the shift-register value it would produce.
  assign bit_c     = cnt_ovf | (cnt_in >= thr);
  assign sr_next_c = {sr, bit_c};

  // Byte completion, end-of-frame and timeout conditions for this cycle.
  assign byte_done_c = cnt_valid && (state == PAYLOAD) && (bitcnt == 3'd7);
  assign last_c      = (bytecnt == (len - BYTE_W'(1)));
  assign to_hit_c    = (state != HUNT) && !cnt_valid &&
                       (to_cnt == TO_W'(TIMEOUT - 1));

  assign load_beat_c.last = last_c;
  assign load_beat_c.data = sr_next_c;

  vlc_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (byte_done_c),
    .load_beat (load_beat_c),
    .ready     (byte_ready),
    .valid     (out_valid),
    .beat      (out_beat),
    .drop_c    (drop_c)
  );

  assign byte_valid = out_valid;
  assign byte_data  = out_beat.data;
  assign byte_last  = out_beat.last;

  // Framing FSM with bit/byte/timeout counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      sr        <= '0;
      bitcnt    <= '0;
      len       <= '0;
      bytecnt   <= '0;
      to_cnt    <= '0;
      sync_lock <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      err_drop <= 1'b0;
      if (cnt_valid) begin
        sr <= sr_next_c[BYTE_W-2:0];
      end
      case (state)
        HUNT: begin
          to_cnt <= '0;
          if (cnt_valid && (sr_next_c == SYNC_WORD)) begin
            state     <= LEN;
            sync_lock <= 1'b1;
            bitcnt    <= '0;
          end
        end
        LEN, PAYLOAD: begin
          if (cnt_valid) begin
            to_cnt <= '0;
            bitcnt <= bitcnt + 3'd1;
            if ((state == LEN) && (bitcnt == 3'd7)) begin
              len <= sr_next_c;
              if (sr_next_c == '0) begin
                state     <= HUNT;
                sync_lock <= 1'b0;
              end else begin
                state   <= PAYLOAD;
                bytecnt <= '0;
              end
            end
            if (byte_done_c) begin
              if (drop_c) begin
                state     <= HUNT;
                sync_lock <= 1'b0;
                err_drop  <= 1'b1;
              end else if (last_c) begin
                state     <= HUNT;
                sync_lock <= 1'b0;
              end else begin
                bytecnt <= bytecnt + BYTE_W'(1);
              end
            end
          end else if (to_hit_c) begin
            state     <= HUNT;
            sync_lock <= 1'b0;
            err_drop  <= 1'b1;
            to_cnt    <= '0;
            bitcnt    <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: begin
          state     <= HUNT;
          sync_lock <= 1'b0;
        end
      endcase
    end
  end

endmodule
